// File: rtl/seqchk_param.sv
// Parametrised serial pattern detector with loadable pattern,
// overlap control, saturating hit counter and sticky active-low LED.
module seqchk_param #(
    parameter int                 PAT_LEN = 7,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(7'b1110010),
    parameter int                 CNT_W   = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               seq_vld,
    input  logic               seq_bit,
    input  logic               ovl_mode,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clr,
    output logic               hit,
    output logic               led,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] shreg;
    logic [PAT_LEN-1:0] shreg_nxt;
    logic [FILL_W-1:0]  fill;
    logic               shift_en;
    logic               match;

    // A load cycle swallows any bit presented alongside it.
    always_comb begin
        shift_en  = seq_vld & ~pat_load;
        shreg_nxt = {shreg[PAT_LEN-2:0], seq_bit};
        match     = shift_en && (fill >= FILL_THR) && (shreg_nxt == pattern);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pattern <= PAT_RST;
            shreg   <= '0;
            fill    <= '0;
        end else if (pat_load) begin
            pattern <= pat_in;
            fill    <= '0;
        end else if (shift_en) begin
            shreg <= shreg_nxt;
            if (match && !ovl_mode) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // clr wins over a coincident hit; the pulse itself still goes out.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hit     <= 1'b0;
            led     <= 1'b1;
            hit_cnt <= '0;
        end else begin
            hit <= match;
            if (clr) begin
                hit_cnt <= '0;
                led     <= 1'b1;
            end else if (match) begin
                led <= 1'b0;
                if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seqchk_param.sv
// Vector-table bench for seqchk_param; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_seqchk_param;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       seq_vld = 1'b0;
    logic       seq_bit = 1'b0;
    logic       ovl_mode = 1'b0;
    logic       pat_load = 1'b0;
    logic [6:0] pat_in = '0;
    logic       clr = 1'b0;
    logic       hit8, led8, hit2, led2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    always #5 sys_clk = ~sys_clk;

    seqchk_param dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .seq_vld(seq_vld), .seq_bit(seq_bit),
        .ovl_mode(ovl_mode), .pat_load(pat_load),
        .pat_in(pat_in), .clr(clr),
        .hit(hit8), .led(led8), .hit_cnt(cnt8)
    );

    seqchk_param #(.CNT_W(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .seq_vld(seq_vld), .seq_bit(seq_bit),
        .ovl_mode(ovl_mode), .pat_load(pat_load),
        .pat_in(pat_in), .clr(clr),
        .hit(hit2), .led(led2), .hit_cnt(cnt2)
    );

    typedef struct {
        logic       vld;
        logic       b;
        logic       ovl;
        logic       load;
        logic [6:0] pat;
        logic       clr;
        logic       hit;
        logic       led;
        int         cnt;
    } vec_t;

    typedef struct {
        logic hit;
        logic led;
        int   cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   ecnt;
    logic eled;
    int   checks = 0;
    int   errors = 0;
    int   row = 0;

    task automatic add(input logic vld, input logic b, input logic ovl,
                       input logic load, input logic [6:0] pat,
                       input logic c, input logic h);
        vec_t v;
        v.vld = vld; v.b = b; v.ovl = ovl; v.load = load;
        v.pat = pat; v.clr = c; v.hit = h;
        if (c) begin
            ecnt = 0;
            eled = 1'b1;
        end else if (h) begin
            ecnt++;
            eled = 1'b0;
        end
        v.led = eled;
        v.cnt = ecnt;
        tbl.push_back(v);
    endtask

    // bits/hm are MSB-first: bit 0 of the stream is bits[n-1]
    task automatic add_bits(input logic [15:0] bits, input int n,
                            input logic ovl, input logic [15:0] hm);
        for (int i = 0; i < n; i++)
            add(1'b1, bits[n-1-i], ovl, 1'b0, 7'd0, 1'b0, hm[n-1-i]);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
        end
    endtask

    task automatic check_outs(input exp_t e);
        chk("hit", 32'(hit8), 32'(e.hit));
        chk("led", 32'(led8), 32'(e.led));
        chk("hit_cnt", 32'(cnt8), (e.cnt > 255) ? 32'd255 : 32'(e.cnt));
        chk("hit_w2", 32'(hit2), 32'(e.hit));
        chk("led_w2", 32'(led2), 32'(e.led));
        chk("hit_cnt_w2", 32'(cnt2), (e.cnt > 3) ? 32'd3 : 32'(e.cnt));
    endtask

    task automatic run_tbl();
        vec_t v;
        exp_t e;
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            seq_vld  = v.vld;
            seq_bit  = v.b;
            ovl_mode = v.ovl;
            pat_load = v.load;
            pat_in   = v.pat;
            clr      = v.clr;
            sb.push_back('{v.hit, v.led, v.cnt});
            @(posedge sys_clk);
            #1;
            row++;
            e = sb.pop_front();
            check_outs(e);
        end
        seq_vld  = 1'b0;
        pat_load = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        logic [6:0] p4;
        logic       bt;
        p4   = 7'b1110010;
        ecnt = 0;
        eled = 1'b1;

        #1 sys_rst = 1'b1;
        #2;
        check_outs('{1'b0, 1'b1, 0});
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // default pattern, single hit
        add_bits(16'b1110010, 7, 1'b0, 16'b0000001);
        add(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);

        // overlapping 1010101; the bit beside the load is ignored
        add(1'b1, 1'b1, 1'b1, 1'b1, 7'b1010101, 1'b0, 1'b0);
        add_bits(16'b10101010101, 11, 1'b1, 16'b00000010101);

        // non-overlapping: next hit needs 7 fresh bits
        add(1'b0, 1'b0, 1'b0, 1'b1, 7'b1010101, 1'b1, 1'b0);
        add_bits(16'b101010101010101, 15, 1'b0, 16'b000000100000001);

        // gaps of 1-3 idle cycles between pattern bits
        add(1'b0, 1'b0, 1'b0, 1'b1, p4, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bt = p4[6-i];
            add(1'b1, bt, 1'b0, 1'b0, 7'd0, 1'b0, i == 6);
            if (i < 6)
                for (int g = 0; g < (i % 3) + 1; g++)
                    add(1'b0, ~bt, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        end

        // load aborts a partial match of the old pattern
        add(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        add_bits(16'b1110, 4, 1'b0, 16'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 7'b0000001, 1'b0, 1'b0);
        add_bits(16'b0000001, 7, 1'b0, 16'b1);

        // saturation, clr against a hit, load against a match
        add(1'b0, 1'b0, 1'b1, 1'b1, 7'b1111111, 1'b1, 1'b0);
        add_bits(16'h7FF, 11, 1'b1, 16'b00000011111);
        add(1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 7'b1111111, 1'b0, 1'b0);
        add_bits(16'h7F, 7, 1'b1, 16'b1);
        run_tbl();

        // async reset right after a hit, checked before the next edge
        seq_vld  = 1'b1;
        seq_bit  = 1'b1;
        ovl_mode = 1'b1;
        @(posedge sys_clk);
        #1;
        row++;
        ecnt++;
        check_outs('{1'b1, 1'b0, ecnt});
        #1 sys_rst = 1'b1;
        #1;
        row++;
        ecnt = 0;
        eled = 1'b1;
        check_outs('{1'b0, 1'b1, 0});
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        seq_vld  = 1'b0;
        ovl_mode = 1'b0;

        // pattern back to default, history cleared
        add_bits(16'b1100101110010, 13, 1'b0, 16'b1);
        run_tbl();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
